// File: rtl/mcu_pkg.sv
// mcu_pkg: shared encodings for the multicycle RV32I control unit.
// FSM states, instruction classes, opcodes, ALU codes, PC/WB selects.
package mcu_pkg;

    typedef enum logic [2:0] {
        RESET, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, FAULT, TRAP
    } state_e;

    typedef enum logic [3:0] {
        CL_ALU_R, CL_ALU_I, CL_LOAD, CL_STORE, CL_BRANCH,
        CL_JAL, CL_JALR, CL_LUI, CL_AUIPC, CL_ILLEGAL
    } iclass_e;

    typedef enum logic [1:0] {
        PC_PLUS4 = 2'd0, PC_REL = 2'd1, PC_JALR = 2'd2, PC_TRAP = 2'd3
    } pc_src_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0, WB_MDR = 2'd1, WB_PC4 = 2'd2, WB_IMM = 2'd3
    } wb_sel_e;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    // alt selects SUB/SRA over ADD/SRL
    function automatic logic [3:0] alu_from_f3(
        input logic [2:0] f3,
        input logic       alt
    );
        logic [3:0] op;
        unique case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/mcu_decoder.sv
// mcu_decoder: combinational RV32I classifier.
// Produces instruction class, ALU operation and an illegal flag.
module mcu_decoder
    import mcu_pkg::*;
(
    input  logic [31:0] instr,
    output iclass_e     iclass,
    output logic [3:0]  alu_op,
    output logic        illegal
);

    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       bad;

    assign op = instr[6:0];
    assign f3 = instr[14:12];
    assign f7 = instr[31:25];

    always_comb begin
        iclass = CL_ILLEGAL;
        alu_op = ALU_ADD;
        bad    = 1'b1;
        unique case (1'b1)
            op == OP_REG: begin
                iclass = CL_ALU_R;
                alu_op = alu_from_f3(f3, f7[5]);
                bad    = !((f7 == 7'h00) ||
                           (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)));
            end
            op == OP_IMM: begin
                iclass = CL_ALU_I;
                alu_op = alu_from_f3(f3, (f3 == 3'b101) && f7[5]);
                bad    = ((f3 == 3'b001) && (f7 != 7'h00)) ||
                         ((f3 == 3'b101) && (f7 != 7'h00) && (f7 != 7'h20));
            end
            op == OP_LOAD: begin
                iclass = CL_LOAD;
                bad    = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            op == OP_STORE: begin
                iclass = CL_STORE;
                bad    = (f3 > 3'b010);
            end
            op == OP_BRANCH: begin
                iclass = CL_BRANCH;
                alu_op = ALU_SUB;
                bad    = (f3 == 3'b010) || (f3 == 3'b011);
            end
            op == OP_JAL: begin
                iclass = CL_JAL;
                bad    = 1'b0;
            end
            op == OP_JALR: begin
                iclass = CL_JALR;
                bad    = (f3 != 3'b000);
            end
            op == OP_LUI: begin
                iclass = CL_LUI;
                bad    = 1'b0;
            end
            op == OP_AUIPC: begin
                iclass = CL_AUIPC;
                bad    = 1'b0;
            end
            default: ;
        endcase
        illegal = bad;
        if (bad) begin
            iclass = CL_ILLEGAL;
            alu_op = ALU_ADD;
        end
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: RV32I control FSM over a req/ready memory port.
// Define MCU_ILLEGAL_TRAP_EN to trap illegal encodings instead of NOPing them.
module multicycle_control_unit
    import mcu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32,
    parameter int ALU_OP_W    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [31:0]         instr,
    input  logic                branch_taken,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic                mem_addr_sel,
    output logic [2:0]          mem_funct3,
    output logic                ir_load,
    output logic                mdr_load,
    output logic                pc_write,
    output logic [1:0]          pc_src,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                alu_src_a,
    output logic                alu_src_b,
    output logic                rf_we,
    output logic [1:0]          wb_sel,
    output logic                retire,
    output logic [CNT_W-1:0]    instret,
    output logic                mem_fault,
    output logic                illegal
);

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
    localparam bit TO_EN = (MEM_TIMEOUT > 0);

    state_e            state;
    state_e            nxt;
    logic [WAIT_W-1:0] wait_cnt;
    iclass_e           iclass;
    logic [3:0]        dec_alu;
    logic              dec_illegal;
    logic [3:0]        ex_op;
    logic              ex_a;
    logic              ex_b;
    logic              mem_phase;
    logic              timeout;

    mcu_decoder u_dec (
        .instr   (instr),
        .iclass  (iclass),
        .alu_op  (dec_alu),
        .illegal (dec_illegal)
    );

    assign mem_phase = (state == FETCH) || (state == MEM);
    assign timeout   = TO_EN && (wait_cnt == WAIT_LAST) && !mem_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= RESET;
            wait_cnt <= '0;
            instret  <= '0;
        end else begin
            state    <= nxt;
            wait_cnt <= (mem_phase && !mem_ready) ? wait_cnt + 1'b1 : '0;
            if (retire) instret <= instret + 1'b1;
        end
    end

    // ALU selects per class, held from EXECUTE through MEM/WRITEBACK
    always_comb begin
        ex_op = ALU_ADD;
        ex_a  = 1'b0;
        ex_b  = 1'b0;
        unique case (iclass)
            CL_ALU_R: ex_op = dec_alu;
            CL_ALU_I: begin
                ex_op = dec_alu;
                ex_b  = 1'b1;
            end
            CL_LOAD, CL_STORE: ex_b = 1'b1;
            CL_BRANCH: ex_op = ALU_SUB;
            CL_AUIPC: begin
                ex_a = 1'b1;
                ex_b = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        nxt          = state;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        mem_funct3   = 3'b000;
        ir_load      = 1'b0;
        mdr_load     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = PC_PLUS4;
        alu_op       = '0;
        alu_src_a    = 1'b0;
        alu_src_b    = 1'b0;
        rf_we        = 1'b0;
        wb_sel       = WB_ALU;
        retire       = 1'b0;
        mem_fault    = 1'b0;
        illegal      = 1'b0;
        unique case (state)
            RESET: nxt = FETCH;
            FETCH: begin
                mem_req    = 1'b1;
                mem_funct3 = 3'b010;
                if (mem_ready) begin
                    ir_load = 1'b1;
                    nxt     = DECODE;
                end else if (timeout) begin
                    nxt = FAULT;
                end
            end
            DECODE: begin
`ifdef MCU_ILLEGAL_TRAP_EN
                nxt = dec_illegal ? TRAP : EXECUTE;
`else
                nxt = dec_illegal ? WRITEBACK : EXECUTE;
`endif
            end
            EXECUTE: begin
                alu_op    = ALU_OP_W'(ex_op);
                alu_src_a = ex_a;
                alu_src_b = ex_b;
                nxt       = WRITEBACK;
                if (iclass == CL_BRANCH) begin
                    pc_write = 1'b1;
                    pc_src   = branch_taken ? PC_REL : PC_PLUS4;
                    retire   = 1'b1;
                    nxt      = FETCH;
                end else if (iclass == CL_LOAD || iclass == CL_STORE) begin
                    nxt = MEM;
                end
            end
            MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_funct3   = instr[14:12];
                mem_we       = (iclass == CL_STORE);
                alu_op       = ALU_OP_W'(ex_op);
                alu_src_b    = ex_b;
                if (mem_ready) begin
                    if (iclass == CL_STORE) begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                        nxt      = FETCH;
                    end else begin
                        mdr_load = 1'b1;
                        nxt      = WRITEBACK;
                    end
                end else if (timeout) begin
                    nxt = FAULT;
                end
            end
            WRITEBACK: begin
                alu_op    = ALU_OP_W'(ex_op);
                alu_src_a = ex_a;
                alu_src_b = ex_b;
                pc_write  = 1'b1;
                retire    = 1'b1;
                rf_we     = (iclass != CL_ILLEGAL) && (instr[11:7] != 5'd0);
                nxt       = FETCH;
                unique case (iclass)
                    CL_LOAD: wb_sel = WB_MDR;
                    CL_JAL: begin
                        wb_sel = WB_PC4;
                        pc_src = PC_REL;
                    end
                    CL_JALR: begin
                        wb_sel = WB_PC4;
                        pc_src = PC_JALR;
                    end
                    CL_LUI: wb_sel = WB_IMM;
                    default: ;
                endcase
            end
            FAULT: mem_fault = 1'b1;
            TRAP: begin
`ifdef MCU_ILLEGAL_TRAP_EN
                pc_write = 1'b1;
                pc_src   = PC_TRAP;
                illegal  = 1'b1;
`endif
                nxt = FETCH;
            end
            default: nxt = RESET;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: random instruction stream against a
// transaction-level model of the control unit's per-cycle outputs.
module tb_multicycle_control_unit;

    localparam int TO    = 4;
    localparam int CNT_W = 4;

    localparam int K_R     = 0;
    localparam int K_I     = 1;
    localparam int K_LD    = 2;
    localparam int K_ST    = 3;
    localparam int K_BR    = 4;
    localparam int K_JAL   = 5;
    localparam int K_JALR  = 6;
    localparam int K_LUI   = 7;
    localparam int K_AUIPC = 8;
    localparam int K_BAD   = 9;

    typedef struct packed {
        logic       req;
        logic       we;
        logic       asel;
        logic [2:0] f3;
        logic       irl;
        logic       mdrl;
        logic       pcw;
        logic [1:0] pcs;
        logic [3:0] aop;
        logic       sa;
        logic       sb;
        logic       rfwe;
        logic [1:0] wbs;
        logic       ret;
        logic       flt;
        logic       ill;
    } ov_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [31:0]      instr = 32'h0;
    logic             branch_taken = 1'b0;
    logic             mem_ready = 1'b0;
    logic             mem_req;
    logic             mem_we;
    logic             mem_addr_sel;
    logic [2:0]       mem_funct3;
    logic             ir_load;
    logic             mdr_load;
    logic             pc_write;
    logic [1:0]       pc_src;
    logic [3:0]       alu_op;
    logic             alu_src_a;
    logic             alu_src_b;
    logic             rf_we;
    logic [1:0]       wb_sel;
    logic             retire;
    logic [CNT_W-1:0] instret;
    logic             mem_fault;
    logic             illegal;

    ov_t obs;
    ov_t full_m;
    int  n_cmp = 0;
    int  n_bad = 0;
    int  exp_instret = 0;

    always #5 clk = ~clk;

    multicycle_control_unit #(
        .MEM_TIMEOUT (TO),
        .CNT_W       (CNT_W),
        .ALU_OP_W    (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr        (instr),
        .branch_taken (branch_taken),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .mem_funct3   (mem_funct3),
        .ir_load      (ir_load),
        .mdr_load     (mdr_load),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .alu_op       (alu_op),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .rf_we        (rf_we),
        .wb_sel       (wb_sel),
        .retire       (retire),
        .instret      (instret),
        .mem_fault    (mem_fault),
        .illegal      (illegal)
    );

    assign obs = {mem_req, mem_we, mem_addr_sel, mem_funct3, ir_load,
                  mdr_load, pc_write, pc_src, alu_op, alu_src_a,
                  alu_src_b, rf_we, wb_sel, retire, mem_fault, illegal};

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic step(input string tag, input ov_t e, input ov_t m);
        #1;
        check(tag, 64'(obs & m), 64'(e & m));
        @(posedge clk);
        #1;
    endtask

    function automatic int kind_of(input logic [31:0] w);
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        op = w[6:0];
        f3 = w[14:12];
        f7 = w[31:25];
        case (op)
            7'h33: return (f7 == 0 || (f7 == 7'h20 && f3 inside {0, 5}))
                          ? K_R : K_BAD;
            7'h13: begin
                if (f3 == 1) return (f7 == 0) ? K_I : K_BAD;
                if (f3 == 5) return (f7 inside {0, 7'h20}) ? K_I : K_BAD;
                return K_I;
            end
            7'h03: return (f3 inside {0, 1, 2, 4, 5}) ? K_LD : K_BAD;
            7'h23: return (f3 <= 2) ? K_ST : K_BAD;
            7'h63: return (f3 inside {0, 1, 4, 5, 6, 7}) ? K_BR : K_BAD;
            7'h6f: return K_JAL;
            7'h67: return (f3 == 0) ? K_JALR : K_BAD;
            7'h37: return K_LUI;
            7'h17: return K_AUIPC;
            default: return K_BAD;
        endcase
    endfunction

    // funct3 -> ADD SLL SLT SLTU XOR SRL OR AND; alt bumps ADD->SUB, SRL->SRA
    function automatic logic [3:0] exp_alu(input logic [31:0] w, input int k);
        int   base [8];
        logic alt;
        base = '{0, 7, 5, 6, 4, 8, 3, 2};
        alt  = w[30] && ((k == K_R && w[14:12] == 0) || w[14:12] == 5);
        return 4'(base[w[14:12]] + int'(alt));
    endfunction

    function automatic logic [31:0] gen_word();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 11))
            0: begin
                w[6:0]   = 7'h33;
                w[31:25] = w[31] ? 7'h20 : 7'h00;
            end
            1: w[6:0] = 7'h13;
            2: begin
                w[6:0]   = 7'h13;
                w[14:12] = w[12] ? 3'b001 : 3'b101;
                w[31:25] = w[31] ? 7'h20 : 7'h00;
            end
            3: w[6:0] = 7'h03;
            4: w[6:0] = 7'h23;
            5: w[6:0] = 7'h63;
            6: w[6:0] = 7'h6f;
            7: begin
                w[6:0]   = 7'h67;
                w[14:12] = w[13] ? w[14:12] : 3'b000;
            end
            8: w[6:0] = 7'h37;
            9: w[6:0] = 7'h17;
            10: w = 32'hFFFF_FFFF;
            default: ;
        endcase
        if ($urandom_range(0, 7) == 0) w[11:7] = 5'd0;
        return w;
    endfunction

    function automatic int pick_delay();
        return ($urandom_range(0, 24) == 0) ? $urandom_range(TO, TO + 2)
                                           : $urandom_range(0, TO - 1);
    endfunction

    task automatic bump();
        exp_instret = (exp_instret + 1) % (1 << CNT_W);
    endtask

    task automatic do_reset();
        ov_t z;
        z     = '0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            mem_ready    = 1'($urandom);
            branch_taken = 1'($urandom);
            check("rst_instret", 64'(instret), 64'(0));
            step("rst_out", z, full_m);
        end
        rst_n     = 1'b1;
        mem_ready = 1'b0;
        step("rst_release", z, full_m);
        exp_instret = 0;
    endtask

    task automatic fault_path();
        ov_t e;
        for (int i = 0; i < 3; i++) begin
            mem_ready = 1'($urandom);
            e         = '0;
            e.flt     = 1'b1;
            step("fault", e, full_m);
        end
        do_reset();
    endtask

    task automatic run_instr(input logic [31:0] w, input int fd,
                             input int md, input logic bt);
        ov_t e;
        ov_t m;
        int  k;
        k = kind_of(w);
        check("instret", 64'(instret), 64'(exp_instret));
        for (int c = 0; ; c++) begin
            mem_ready = (c == fd);
            e         = '0;
            e.req     = 1'b1;
            e.f3      = 3'b010;
            e.irl     = (c == fd);
            step("fetch", e, full_m);
            if (c == fd) break;
            if (c == TO - 1) begin
                fault_path();
                return;
            end
        end
        instr        = w;
        branch_taken = bt;
        mem_ready    = 1'($urandom);
        e            = '0;
        step("decode", e, full_m);
        if (k == K_BAD) begin
`ifdef MCU_ILLEGAL_TRAP_EN
            e     = '0;
            e.pcw = 1'b1;
            e.pcs = 2'd3;
            e.ill = 1'b1;
            step("trap", e, full_m);
`else
            e     = '0;
            e.pcw = 1'b1;
            e.ret = 1'b1;
            m     = full_m;
            m.aop = '0;
            m.sa  = 1'b0;
            m.sb  = 1'b0;
            m.wbs = '0;
            step("nop_wb", e, m);
            bump();
`endif
            return;
        end
        mem_ready = 1'($urandom);
        e         = '0;
        m         = full_m;
        case (k)
            K_R, K_I: begin
                e.aop = exp_alu(w, k);
                e.sb  = (k == K_I);
            end
            K_AUIPC: begin
                e.sa = 1'b1;
                e.sb = 1'b1;
            end
            K_LD, K_ST: e.sb = 1'b1;
            K_BR: begin
                e.aop = 4'd1;
                e.pcw = 1'b1;
                e.pcs = bt ? 2'd1 : 2'd0;
                e.ret = 1'b1;
            end
            default: begin
                m.aop = '0;
                m.sa  = 1'b0;
                m.sb  = 1'b0;
            end
        endcase
        step("exec", e, m);
        if (k == K_BR) begin
            bump();
            return;
        end
        if (k == K_LD || k == K_ST) begin
            for (int c = 0; ; c++) begin
                mem_ready = (c == md);
                e         = '0;
                e.req     = 1'b1;
                e.asel    = 1'b1;
                e.f3      = w[14:12];
                e.we      = (k == K_ST);
                e.sb      = 1'b1;
                if (c == md) begin
                    e.mdrl = (k == K_LD);
                    e.pcw  = (k == K_ST);
                    e.ret  = (k == K_ST);
                end
                step("mem", e, full_m);
                if (c == md) break;
                if (c == TO - 1) begin
                    fault_path();
                    return;
                end
            end
            if (k == K_ST) begin
                bump();
                return;
            end
        end
        mem_ready = 1'($urandom);
        e         = '0;
        m         = full_m;
        m.aop     = '0;
        m.sa      = 1'b0;
        m.sb      = 1'b0;
        e.rfwe    = (w[11:7] != 5'd0);
        e.wbs     = (k == K_LD) ? 2'd1 :
                    (k == K_JAL || k == K_JALR) ? 2'd2 :
                    (k == K_LUI) ? 2'd3 : 2'd0;
        e.pcw     = 1'b1;
        e.pcs     = (k == K_JAL) ? 2'd1 : (k == K_JALR) ? 2'd2 : 2'd0;
        e.ret     = 1'b1;
        step("wb", e, m);
        bump();
    endtask

    initial begin
        full_m = '1;
        do_reset();
        run_instr(32'h0050_0093, 0, 0, 1'b0);
        run_instr(32'h0040_2103, 0, 3, 1'b0);
        run_instr(32'h0000_0063, 1, 0, 1'b1);
        run_instr(32'h0000_0063, 0, 0, 1'b0);
        run_instr(32'hFFFF_FFFF, 2, 0, 1'b0);
        run_instr(32'h0010_a023, 0, 1, 1'b0);
        #1;
        check("midrst_req_before", 64'(mem_req), 64'(1));
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_req_after", 64'(mem_req), 64'(0));
        do_reset();
        run_instr(32'h0050_0093, TO + 3, 0, 1'b0);
        for (int i = 0; i < 400; i++) begin
            run_instr(gen_word(), pick_delay(), pick_delay(),
                      1'($urandom));
        end
        #1;
        check("instret_end", 64'(instret), 64'(exp_instret));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
